data_mem_responder: RTL and testbench

- Bus responder (data memory) at the far end of the CPU data bus, which is driven by the datapath's busAddr/busWData/byte-enable lanes.
- Accepts one word-aligned read or write request at a time.
- Applies per-byte write enables, inserts a configurable number of wait states, then returns a one-cycle ready pulse with read data or an error flag.
- Byte/halfword extraction and sign extension stay in the initiator; this block always returns the full 32-bit word.

---
 rtl/data_bus_pkg.sv | 33 +++
 rtl/data_mem_responder_if.sv | 36 +++
 rtl/byte_lane_ram.sv | 36 +++
 rtl/data_mem_responder.sv | 113 +++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_pkg.sv
// Shared types and helpers for the data-bus responder: FSM state encoding and
// the set of byte-enable patterns the initiator is allowed to issue on writes.
package data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    localparam int WAIT_CNT_WIDTH = 4;

    // Only naturally aligned byte, halfword and word lanes are accepted.
    function automatic logic be_is_legal(input logic [3:0] be);
        logic legal;
        legal = 1'b0;
        case (be)
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
            BE_HALF0, BE_HALF1, BE_WORD: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-bus signal bundle between the datapath (master) and a memory
// responder (slave).
interface data_mem_responder_if;

    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  busByteEnable;
    logic        busReady;
    logic [31:0] busRData;
    logic        busErr;

    modport master (
        output busReq,
        output busWe,
        output busAddr,
        output busWData,
        output busByteEnable,
        input  busReady,
        input  busRData,
        input  busErr
    );

    modport slave (
        input  busReq,
        input  busWe,
        input  busAddr,
        input  busWData,
        input  busByteEnable,
        output busReady,
        output busRData,
        output busErr
    );

endinterface

// File: rtl/byte_lane_ram.sv
// Single-port word RAM built from four independent byte lanes, each with its
// own write enable and a registered, enable-gated read port.
module byte_lane_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            wr_be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  rd_en,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
                // Output register holds its value between reads.
                if (rd_en) begin
                    lane_q_reg <= lane_mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory bus responder: captures one request, waits WAIT_CYCLES, performs
// the checked access and returns a one-cycle ready pulse with data or error.
module data_mem_responder
    import data_bus_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES);

    bus_state_t                 state_reg;
    logic [WAIT_CNT_WIDTH-1:0]  count_reg;
    logic                       we_reg;
    logic                       in_range_reg;
    logic [ADDR_WIDTH-1:0]      idx_reg;
    logic [31:0]                wdata_reg;
    logic [3:0]                 be_reg;
    logic                       ready_reg;
    logic                       err_reg;
    logic                       rd_valid_reg;

    logic [31:0]                req_offset;
    logic                       req_in_range;
    logic [ADDR_WIDTH-1:0]      req_idx;

    logic                       access_fire;
    logic                       access_err;
    logic                       access_rd;
    logic                       access_wr;
    logic [3:0]                 ram_we;
    logic                       ram_rd_en;
    logic [31:0]                ram_rdata;

    // Modular subtraction makes addresses below the base wrap far out of range.
    assign req_offset   = bus.busAddr - BASE_ADDR;
    assign req_in_range = (req_offset[31:ADDR_WIDTH+2] == '0);
    assign req_idx      = req_offset[ADDR_WIDTH+1:2];

    assign access_fire = (state_reg == ACCESS) && (count_reg == '0);
    assign access_err  = !in_range_reg || (we_reg && !be_is_legal(be_reg));
    assign access_wr   = we_reg && !access_err;
    assign access_rd   = !we_reg && in_range_reg;

    // Reset in the access cycle suppresses the memory side effect entirely.
    assign ram_we    = (access_fire && access_wr && !reset) ? be_reg : 4'b0000;
    assign ram_rd_en = access_fire && access_rd && !reset;

    byte_lane_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .wr_be (ram_we),
        .addr  (idx_reg),
        .wdata (wdata_reg),
        .rd_en (ram_rd_en),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            ready_reg    <= 1'b0;
            err_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b0;
                    if (bus.busReq) begin
                        we_reg       <= bus.busWe;
                        in_range_reg <= req_in_range;
                        idx_reg      <= req_idx;
                        wdata_reg    <= bus.busWData;
                        be_reg       <= bus.busByteEnable;
                        count_reg    <= WAIT_LOAD;
                        state_reg    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count_reg != '0) begin
                        count_reg <= count_reg - 1'b1;
                    end else begin
                        ready_reg    <= 1'b1;
                        err_reg      <= access_err;
                        rd_valid_reg <= access_rd;
                        state_reg    <= RESP;
                    end
                end
                RESP: begin
                    ready_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The RAM output register carries read data; writes and errors return zero.
    assign bus.busReady = ready_reg;
    assign bus.busErr   = err_reg;
    assign bus.busRData = rd_valid_reg ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder with a word-array
// reference model; also checks back-to-back timing for 0 and 15 wait states.
module tb_data_mem_responder;

    localparam int          AW    = 10;
    localparam int          DEPTH = 2 ** AW;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if bus1();
    data_mem_responder_if bus0();
    data_mem_responder_if bus15();

    data_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    data_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    data_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(15))
        dut15 (.clk(clk), .reset(reset), .bus(bus15));

    int n_assert = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    logic [31:0] model_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer on the WAIT_CYCLES=1 instance, checked against the model.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input string tag, output logic [31:0] rdata_obs);
        logic [31:0] offset;
        bit          in_rng;
        int          idx;
        bit          legal;
        logic        exp_err;
        logic [31:0] exp_data;
        int          lat;

        offset   = addr - BASE;
        in_rng   = (offset < 32'(4 * DEPTH));
        idx      = in_rng ? int'(offset / 4) : 0;
        legal    = (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
        exp_err  = !in_rng || (we && !legal);
        exp_data = (!we && in_rng) ? model_mem[idx] : 32'h0;
        if (we && !exp_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
            end
        end

        bus1.busReq        = 1'b1;
        bus1.busWe         = we;
        bus1.busAddr       = addr;
        bus1.busWData      = wdata;
        bus1.busByteEnable = be;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus1.busReady && lat < 40);
        rdata_obs = bus1.busRData;
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_err"}, {31'b0, bus1.busErr}, {31'b0, exp_err});
        check({tag, "_rdata"}, bus1.busRData, exp_data);
        $display("txn %0d %s we=%0b addr=%h wdata=%h be=%b ready_after=%0d rdata=%h err=%0b",
                 n_txn, tag, we, addr, wdata, be, lat, bus1.busRData, bus1.busErr);
        n_txn++;
        bus1.busReq = 1'b0;
        @(posedge clk); #1;
        check({tag, "_pulse_width"}, {31'b0, bus1.busReady}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  be_pool [9];
        int          pick_idx [8];
        int          stamps [$];
        int          ready_ones;

        be_pool = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0101, 4'b0000};
        pick_idx = '{0, 1, 2, 3, DEPTH-4, DEPTH-3, DEPTH-2, DEPTH-1};

        bus1.busReq = 0;  bus1.busWe = 0;  bus1.busAddr = 0;  bus1.busWData = 0;  bus1.busByteEnable = 0;
        bus0.busReq = 0;  bus0.busWe = 0;  bus0.busAddr = 0;  bus0.busWData = 0;  bus0.busByteEnable = 0;
        bus15.busReq = 0; bus15.busWe = 0; bus15.busAddr = 0; bus15.busWData = 0; bus15.busByteEnable = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, bus1.busReady}, 32'd0);
        check("reset_err", {31'b0, bus1.busErr}, 32'd0);
        check("reset_rdata", bus1.busRData, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full-word write then read back.
        txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, "wr_word", rd);
        txn(1'b0, 32'h1000_0004, 32'h0, 4'b0000, "rd_word", rd);
        check("rd_word_const", rd, 32'hDEAD_BEEF);

        // Partial lane updates.
        txn(1'b1, 32'h1000_0008, 32'h1122_3344, 4'b1111, "preload", rd);
        txn(1'b1, 32'h1000_0008, 32'h00AB_0000, 4'b0100, "wr_byte2", rd);
        txn(1'b0, 32'h1000_0008, 32'h0, 4'b0000, "rd_byte2", rd);
        check("rd_byte2_const", rd, 32'h11AB_3344);
        txn(1'b1, 32'h1000_0008, 32'h5566_0000, 4'b1100, "wr_half1", rd);
        txn(1'b0, 32'h1000_0008, 32'h0, 4'b0000, "rd_half1", rd);
        check("rd_half1_const", rd, 32'h5566_3344);

        // Range boundaries.
        txn(1'b0, 32'h0FFF_FFFC, 32'h0, 4'b0000, "rd_below_base", rd);
        txn(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'b0000, "rd_past_end", rd);
        txn(1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'hA5A5_5A5A, 4'b1111, "wr_last", rd);
        txn(1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'b0000, "rd_last", rd);
        check("rd_last_const", rd, 32'hA5A5_5A5A);

        // Illegal byte enables leave the word intact.
        txn(1'b1, 32'h1000_0008, 32'hFFFF_FFFF, 4'b0101, "wr_be0101", rd);
        txn(1'b1, 32'h1000_0008, 32'hFFFF_FFFF, 4'b0000, "wr_be0000", rd);
        txn(1'b0, 32'h1000_0008, 32'h0, 4'b0000, "rd_after_bad_be", rd);
        check("rd_after_bad_be_const", rd, 32'h5566_3344);

        // Reset on the access edge of a write to word 2 must cancel it.
        bus1.busReq = 1'b1; bus1.busWe = 1'b1; bus1.busAddr = 32'h1000_0008;
        bus1.busWData = 32'hCAFE_F00D; bus1.busByteEnable = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus1.busReq = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready", {31'b0, bus1.busReady}, 32'd0);
        check("rst_mid_err", {31'b0, bus1.busErr}, 32'd0);
        check("rst_mid_rdata", bus1.busRData, 32'd0);
        reset = 1'b0;
        ready_ones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus1.busReady) ready_ones++;
        end
        check("rst_mid_no_ready", 32'(ready_ones), 32'd0);
        txn(1'b0, 32'h1000_0008, 32'h0, 4'b0000, "rd_after_rst", rd);
        check("rd_after_rst_const", rd, 32'h5566_3344);

        // Randomized traffic over a preloaded set of words near both ends.
        foreach (pick_idx[k]) begin
            txn(1'b1, BASE + 32'(4 * pick_idx[k]), $urandom, 4'b1111, "rnd_preload", rd);
        end
        for (int t = 0; t < 40; t++) begin
            logic        we;
            logic [31:0] addr;
            logic [3:0]  be;
            we = 1'($urandom_range(0, 1));
            be = be_pool[$urandom_range(0, 8)];
            case ($urandom_range(0, 7))
                0:       addr = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
                1:       addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
                default: addr = BASE + 32'(4 * pick_idx[$urandom_range(0, 7)]) + 32'($urandom_range(0, 3));
            endcase
            txn(we, addr, $urandom, be, "rnd", rd);
        end

        // Held request, zero wait states: one pulse every 3 cycles.
        bus0.busReq = 1'b1; bus0.busWe = 1'b1; bus0.busAddr = BASE;
        bus0.busWData = 32'h1234_5678; bus0.busByteEnable = 4'b1111;
        stamps.delete();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus0.busReady) stamps.push_back(c);
        end
        bus0.busReq = 1'b0;
        n_assert++;
        assert (stamps.size() >= 12) else begin
            n_fail++;
            $error("FAIL w0_pulse_count observed=%0d expected>=12", stamps.size());
        end
        for (int i = 1; i < stamps.size(); i++) check("w0_period", 32'(stamps[i] - stamps[i-1]), 32'd3);

        // Held request, 15 wait states: one pulse every 18 cycles.
        bus15.busReq = 1'b1; bus15.busWe = 1'b1; bus15.busAddr = BASE + 32'd4;
        bus15.busWData = 32'h8765_4321; bus15.busByteEnable = 4'b1111;
        stamps.delete();
        for (int c = 0; c < 110; c++) begin
            @(posedge clk); #1;
            if (bus15.busReady) stamps.push_back(c);
        end
        bus15.busReq = 1'b0;
        n_assert++;
        assert (stamps.size() >= 5) else begin
            n_fail++;
            $error("FAIL w15_pulse_count observed=%0d expected>=5", stamps.size());
        end
        for (int i = 1; i < stamps.size(); i++) check("w15_period", 32'(stamps[i] - stamps[i-1]), 32'd18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
